// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer
//   Frame scheduler and stereo sample buffer for the I2S transmit path.
//   The block generates lrclk with a period of 2*WORD sclk cycles: low for
//   the left slot and high for the right slot. It buffers stereo pairs from
//   the mixer in a DEPTH-entry FIFO. At each frame boundary it presents one
//   pair on left_chan/right_chan, so the serializer sees stable data across
//   the lrclk rising edge. Frame boundaries that find the FIFO empty are
//   counted as underruns.
//
// Ports
//   sclk, rst        bit clock (posedge), synchronous active-high reset
//   enable           run frame sequencing; 0 parks the frame at position 0
//   s_valid/s_ready  upstream handshake; s_ready = !full && !rst
//   s_left/s_right   upstream stereo pair
//   lrclk            word select, 0 = left slot, 1 = right slot
//   left_chan/right_chan  pair held for the whole frame
//   frame_start      1-cycle pulse after each boundary edge
//   underrun         1-cycle pulse after a boundary that found the FIFO empty
//   underrun_cnt     saturating underrun count
//   fifo_level       entries currently stored
module i2s_tx_sequencer #(
    parameter int BITSIZE   = 24,
    parameter int WORD      = 32,
    parameter int DEPTH     = 4,
    parameter int UFLOW_W   = 16,
    parameter int HOLD_LAST = 0
) (
    input  logic                       sclk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [BITSIZE-1:0]         s_left,
    input  logic [BITSIZE-1:0]         s_right,
    output logic                       lrclk,
    output logic [BITSIZE-1:0]         left_chan,
    output logic [BITSIZE-1:0]         right_chan,
    output logic                       frame_start,
    output logic                       underrun,
    output logic [UFLOW_W-1:0]         underrun_cnt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int FW = $clog2(2*WORD);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [FW-1:0] FLAST = FW'(2*WORD-1);
    localparam logic [FW-1:0] FMID  = FW'(WORD);

    logic [FW-1:0]      fcnt;
    logic [FW-1:0]      fcnt_nxt;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;
    logic [BITSIZE-1:0] mem_l [DEPTH];
    logic [BITSIZE-1:0] mem_r [DEPTH];

    logic full, empty, boundary, push, pop;

    assign full     = (fifo_level == LW'(DEPTH));
    assign empty    = (fifo_level == '0);
    assign boundary = enable && (fcnt == '0);
    // A pop only happens if an entry was already stored before this edge.
    // A push on the same edge lands behind it and is not consumed.
    assign pop      = boundary && !empty;
    assign s_ready  = !full && !rst;
    assign push     = s_valid && s_ready;

    always_comb begin
        fcnt_nxt = '0;
        if (enable)
            fcnt_nxt = (fcnt == FLAST) ? '0 : fcnt + FW'(1);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            fcnt         <= '0;
            lrclk        <= 1'b0;
            left_chan    <= '0;
            right_chan   <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            fifo_level   <= '0;
            wptr         <= '0;
            rptr         <= '0;
        end else begin
            fcnt        <= fcnt_nxt;
            // Registered from the next count, so lrclk tracks the visible fcnt.
            lrclk       <= (fcnt_nxt >= FMID);
            frame_start <= boundary;
            underrun    <= boundary && empty;

            if (pop) begin
                left_chan  <= mem_l[rptr];
                right_chan <= mem_r[rptr];
                rptr       <= rptr + PW'(1);
            end else if (boundary) begin
                if (HOLD_LAST == 0) begin
                    left_chan  <= '0;
                    right_chan <= '0;
                end
                if (underrun_cnt != '1)
                    underrun_cnt <= underrun_cnt + UFLOW_W'(1);
            end

            if (push)
                wptr <= wptr + PW'(1);

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Storage is not reset: the pointers and level define what is valid.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_l[wptr] <= s_left;
            mem_r[wptr] <= s_right;
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Testbench for i2s_tx_sequencer. It runs two instances from the same
// stimulus: one that zeros the outputs on underrun with a 16-bit counter,
// and one that holds the last pair with a 2-bit counter. A queue-based
// reference model predicts every output each cycle. A scoreboard of
// accepted pairs is matched against each non-underrun frame_start.
module tb_i2s_tx_sequencer;

    localparam int BITSIZE = 24;
    localparam int WORD    = 32;
    localparam int DEPTH   = 4;
    localparam int LW      = $clog2(DEPTH+1);

    typedef struct packed {
        logic [BITSIZE-1:0] l;
        logic [BITSIZE-1:0] r;
    } pair_t;

    logic sclk = 1'b0;
    logic rst, enable, s_valid;
    logic [BITSIZE-1:0] s_left, s_right;

    logic               rdy0, lr0, fs0, ur0;
    logic [BITSIZE-1:0] lc0, rc0;
    logic [15:0]        cnt0;
    logic [LW-1:0]      lvl0;
    logic               rdy1, lr1, fs1, ur1;
    logic [BITSIZE-1:0] lc1, rc1;
    logic [1:0]         cnt1;
    logic [LW-1:0]      lvl1;

    always #5 sclk = ~sclk;

    i2s_tx_sequencer #(.BITSIZE(BITSIZE), .WORD(WORD), .DEPTH(DEPTH),
                       .UFLOW_W(16), .HOLD_LAST(0)) dut0 (
        .sclk(sclk), .rst(rst), .enable(enable), .s_valid(s_valid),
        .s_ready(rdy0), .s_left(s_left), .s_right(s_right), .lrclk(lr0),
        .left_chan(lc0), .right_chan(rc0), .frame_start(fs0),
        .underrun(ur0), .underrun_cnt(cnt0), .fifo_level(lvl0));

    i2s_tx_sequencer #(.BITSIZE(BITSIZE), .WORD(WORD), .DEPTH(DEPTH),
                       .UFLOW_W(2), .HOLD_LAST(1)) dut1 (
        .sclk(sclk), .rst(rst), .enable(enable), .s_valid(s_valid),
        .s_ready(rdy1), .s_left(s_left), .s_right(s_right), .lrclk(lr1),
        .left_chan(lc1), .right_chan(rc1), .frame_start(fs1),
        .underrun(ur1), .underrun_cnt(cnt1), .fifo_level(lvl1));

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;
    bit acc;

    // Reference model state (index 0 = zero-on-underrun, 1 = hold-last)
    pair_t              mq[$];
    pair_t              sb[$];
    int                 mpos;
    bit                 mlr, mfs, mur;
    logic [BITSIZE-1:0] ml [2];
    logic [BITSIZE-1:0] mr [2];
    int                 mcnt [2];
    int                 cmax [2] = '{65535, 3};
    bit                 hold [2] = '{1'b0, 1'b1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: frame position counts 0..2*WORD-1 while enabled. Position 0 is
    // the boundary, which takes the oldest stored pair or records an underrun.
    initial begin
        mpos = 0; mlr = 0; mfs = 0; mur = 0;
        for (int k = 0; k < 2; k++) begin ml[k] = '0; mr[k] = '0; mcnt[k] = 0; end
        forever begin : model
            bit bnd, emp, rdy;
            pair_t p;
            @(posedge sclk);
            if (rst) begin
                mq.delete(); sb.delete();
                mpos = 0; mlr = 0; mfs = 0; mur = 0;
                for (int k = 0; k < 2; k++) begin ml[k] = '0; mr[k] = '0; mcnt[k] = 0; end
            end else begin
                rdy = (mq.size() < DEPTH);
                emp = (mq.size() == 0);
                bnd = enable && (mpos == 0);
                if (bnd) begin
                    if (!emp) begin
                        p = mq.pop_front();
                        for (int k = 0; k < 2; k++) begin ml[k] = p.l; mr[k] = p.r; end
                    end else begin
                        for (int k = 0; k < 2; k++) begin
                            if (!hold[k]) begin ml[k] = '0; mr[k] = '0; end
                            if (mcnt[k] < cmax[k]) mcnt[k]++;
                        end
                    end
                end
                if (s_valid && rdy) begin
                    p.l = s_left; p.r = s_right;
                    mq.push_back(p);
                    sb.push_back(p);
                end
                mfs  = bnd;
                mur  = bnd && emp;
                mpos = enable ? (mpos + 1) % (2*WORD) : 0;
                mlr  = (mpos >= WORD);
            end
        end
    end

    // Monitor: per-cycle compare on the falling edge, plus scoreboard match
    // of each delivered frame against the accepted pairs in order.
    initial begin
        forever begin : monitor
            pair_t p;
            @(negedge sclk);
            if (mon_on) begin
                chk("d0.s_ready",      rdy0, !rst && (mq.size() < DEPTH));
                chk("d1.s_ready",      rdy1, !rst && (mq.size() < DEPTH));
                chk("d0.fifo_level",   lvl0, mq.size());
                chk("d1.fifo_level",   lvl1, mq.size());
                chk("d0.lrclk",        lr0,  mlr);
                chk("d1.lrclk",        lr1,  mlr);
                chk("d0.frame_start",  fs0,  mfs);
                chk("d1.frame_start",  fs1,  mfs);
                chk("d0.underrun",     ur0,  mur);
                chk("d1.underrun",     ur1,  mur);
                chk("d0.left_chan",    lc0,  ml[0]);
                chk("d0.right_chan",   rc0,  mr[0]);
                chk("d1.left_chan",    lc1,  ml[1]);
                chk("d1.right_chan",   rc1,  mr[1]);
                chk("d0.underrun_cnt", cnt0, mcnt[0]);
                chk("d1.underrun_cnt", cnt1, mcnt[1]);
                if (fs0 && !mur) begin
                    if (sb.size() == 0) begin
                        chk("sb.nonempty", 0, 1);
                    end else begin
                        p = sb.pop_front();
                        chk("sb.d0.left",  lc0, p.l);
                        chk("sb.d0.right", rc0, p.r);
                        chk("sb.d1.left",  lc1, p.l);
                        chk("sb.d1.right", rc1, p.r);
                    end
                end
            end
        end
    end

    // One clock: note whether the current offer is taken, then move the
    // inputs just after the edge.
    task automatic step();
        @(negedge sclk);
        acc = s_valid && rdy0;
        @(posedge sclk);
        #1;
    endtask

    // Random source: a pending pair stays put until accepted.
    task automatic src_update(input int vprob);
        if (acc || !s_valid) begin
            s_valid = ($urandom_range(99) < vprob);
            s_left  = BITSIZE'($urandom);
            s_right = BITSIZE'($urandom);
        end
    endtask

    task automatic run(input int n, input bit en, input int vprob);
        enable = en;
        repeat (n) begin
            step();
            src_update(vprob);
        end
    endtask

    task automatic push_pair(input logic [BITSIZE-1:0] l, input logic [BITSIZE-1:0] r);
        s_left = l; s_right = r; s_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (acc) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL push_timeout actual=not_accepted expected=accepted t=%0t", $time);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0; acc = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        mon_on = 1'b1;
        rst = 1'b0;

        // Free-running frames with nothing queued: lrclk period, frame_start
        // cadence, underruns, and saturation of the 2-bit counter.
        run(400, 1'b1, 0);

        // Three directed pairs, delivered one per frame and then underrun.
        run(2, 1'b0, 0);
        do_reset();
        push_pair(24'h000001, 24'h800001);
        push_pair(24'h7FFFFF, 24'h123456);
        push_pair(24'hABCDEF, 24'h000010);
        run(260, 1'b1, 0);

        // Fill while stopped, then drain with the source still pushing.
        run(10, 1'b0, 100);
        run(400, 1'b1, 100);
        run(300, 1'b1, 0);

        // Reset partway through a frame with two entries stored.
        enable = 1'b0;
        do_reset();
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        push_pair(24'h555555, 24'h666666);
        run(40, 1'b1, 0);
        do_reset();
        run(70, 1'b1, 0);

        // Random traffic with occasional stalls and resets.
        for (int blk = 0; blk < 30; blk++) begin
            enable = ($urandom_range(9) < 8);
            repeat (100) begin
                rst = ($urandom_range(499) == 0);
                step();
                src_update(60);
            end
            rst = 1'b0;
        end
        run(5, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
